jump_unit: RTL and testbench
============================

JUMP_UNIT -- requirements
Module: jump_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-counter and target width in bits.
REQ-002 Parameter LBL_W, default 8, SHALL set the label width in bits; legal range is 2 to ADDR_W.
REQ-003 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address entries; legal range is 1 to 16.
REQ-004 The block SHALL have exactly one clock and an asynchronous, active-high reset, listed first in the port list as follows.
REQ-005 Port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 Port en, input, 1 bit: operation strobe; when low, all state holds.
REQ-008 Port op, input, 3 bits: operation select (see REQ-013).
REQ-009 Port label, input, LBL_W bits: jump label or offset.
REQ-010 Port cond, input, 1 bit: branch condition for BRC.
REQ-011 Port label_ext, output, ADDR_W bits: label sign-extended to ADDR_W, combinational.
REQ-012 Outputs SHALL be as follows, all registered:
- pc, ADDR_W bits: program counter.
- taken, 1 bit: last op redirected the pc.
- stack_full, 1 bit.
- stack_empty, 1 bit.
- err_ovf, 1 bit: sticky overflow error.
- err_unf, 1 bit: sticky underflow error.

Function
REQ-013 Op encoding SHALL be:
- 000 NEXT
- 001 JMP (absolute)
- 010 BR (relative)
- 011 BRC (conditional relative)
- 100 CALL
- 101 RET
- 110 and 111 are reserved and SHALL behave as NEXT.
REQ-014 label_ext SHALL equal label with bit LBL_W-1 replicated into bits ADDR_W-1..LBL_W; with LBL_W=ADDR_W it SHALL equal label.
REQ-015 Every op SHALL take effect on the rising clock edge where en=1 (one-cycle latency); with en=0, pc, stack, taken and flags SHALL hold.
REQ-016 NEXT SHALL load pc+1 and clear taken.
REQ-017 JMP SHALL load the label zero-extended to ADDR_W and set taken.
REQ-018 BR SHALL load pc+label_ext and set taken.
REQ-019 BRC with cond=1 SHALL behave as BR.
REQ-020 BRC with cond=0 SHALL behave as NEXT.
REQ-021 All pc arithmetic SHALL be modulo 2^ADDR_W:
- pc=2^ADDR_W-1 with NEXT wraps to 0.
- Negative offsets wrap below 0.
REQ-022 CALL with the stack not full SHALL:
- push pc+1 (mod 2^ADDR_W);
- load the zero-extended label;
- set taken.
REQ-023 CALL with stack_full=1 SHALL not push, SHALL behave as NEXT, and SHALL set err_ovf.
REQ-024 RET with the stack not empty SHALL pop the most recent entry (LIFO) into pc and set taken.
REQ-025 RET with stack_empty=1 SHALL behave as NEXT and SHALL set err_unf.
REQ-026 stack_full SHALL be 1 exactly when STACK_DEPTH entries are held; stack_empty SHALL be 1 exactly when 0 entries are held; both SHALL reflect occupancy after the current edge.
REQ-027 err_ovf and err_unf SHALL remain set until reset; subsequent ops SHALL continue to execute normally.
REQ-028 cond and label SHALL be ignored on ops that do not use them.

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, set:
- pc=0, taken=0;
- stack occupancy 0, stack_empty=1, stack_full=0;
- err_ovf=0, err_unf=0.
REQ-030 Reset asserted mid-sequence SHALL discard all stacked return addresses; stack entry contents need not be cleared.
REQ-031 While reset=1, en and op SHALL have no effect; the first op SHALL execute on the first rising edge after reset deasserts.

Verification
REQ-032 Sign extension: with ADDR_W=8, LBL_W=4, label=4'b1010 -> label_ext=8'hFA; label=4'b0101 -> label_ext=8'h05.
REQ-033 Relative branch with wrap: pc=8'h02, BR label=8'hFD (-3) -> pc=8'hFF, taken=1; then NEXT -> pc=8'h00, taken=0.
REQ-034 Conditional branch: pc=8'h10, BRC label=8'h04:
- cond=0 -> pc=8'h11, taken=0;
- repeated from pc=8'h10 with cond=1 -> pc=8'h14, taken=1.
REQ-035 Call/return nesting: from pc=8'h20, CALL 8'h40, then CALL 8'h60, then RET, then RET -> pc sequence 40, 60, 41, 21; stack_empty=1 at end.
REQ-036 Overflow and underflow, STACK_DEPTH=4:
- Five CALLs -> stack_full=1 after the 4th; the 5th acts as NEXT and sets err_ovf=1.
- Five RETs -> the 5th acts as NEXT and sets err_unf=1.
- Both flags stay 1.
REQ-037 Async reset and hold:
- reset pulsed between clock edges with 2 entries stacked -> pc=0, stack_empty=1, flags 0 before the next edge.
- en=0 for 3 cycles with op=JMP -> pc unchanged.

Source files
------------

// File: rtl/jump_unit.sv
// Program-counter sequencer with absolute/relative/conditional jumps and a
// bounded return-address stack for CALL/RET, with sticky overflow/underflow flags.
module jump_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned LBL_W       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [LBL_W-1:0]  label,
  input  logic              cond,
  output logic [ADDR_W-1:0] label_ext,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_BR   = 3'b010,
    OP_BRC  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_e;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic [ADDR_W-1:0] label_zext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] top_entry;
  logic [ADDR_W-1:0] pc_nxt;
  logic              taken_nxt;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic              is_full;
  logic              is_empty;

  assign label_ext  = ADDR_W'($signed(label));
  assign label_zext = ADDR_W'(label);
  assign pc_inc     = pc + ADDR_W'(1);
  assign pc_rel     = pc + label_ext;
  assign is_full    = (count == CNT_W'(STACK_DEPTH));
  assign is_empty   = (count == '0);
  assign top_entry  = stack_mem[IDX_W'(count - CNT_W'(1))];

  // Next-state decode; every op defaults to NEXT behaviour
  always_comb begin
    pc_nxt    = pc_inc;
    taken_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    count_nxt = count;
    case (op_e'(op))
      OP_JMP: begin
        pc_nxt    = label_zext;
        taken_nxt = 1'b1;
      end
      OP_BR: begin
        pc_nxt    = pc_rel;
        taken_nxt = 1'b1;
      end
      OP_BRC: begin
        if (cond) begin
          pc_nxt    = pc_rel;
          taken_nxt = 1'b1;
        end
      end
      OP_CALL: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          push      = 1'b1;
          pc_nxt    = label_zext;
          taken_nxt = 1'b1;
          count_nxt = count + CNT_W'(1);
        end
      end
      OP_RET: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          pop       = 1'b1;
          pc_nxt    = top_entry;
          taken_nxt = 1'b1;
          count_nxt = count - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      taken       <= 1'b0;
      count       <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else if (en) begin
      pc          <= pc_nxt;
      taken       <= taken_nxt;
      count       <= count_nxt;
      stack_full  <= (count_nxt == CNT_W'(STACK_DEPTH));
      stack_empty <= (count_nxt == '0);
      err_ovf     <= err_ovf | ovf_set;
      err_unf     <= err_unf | unf_set;
    end
  end

  // Return-address storage; contents survive reset, only occupancy is cleared
  always_ff @(posedge clock) begin
    if (en && push && !reset) begin
      stack_mem[IDX_W'(count)] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_jump_unit.sv
// Scoreboard bench for jump_unit: stimulus pushes model predictions, a monitor
// compares them against the registered outputs after each rising edge.
module tb_jump_unit;

  localparam int ADDR_W = 8;
  localparam int LBL_W  = 8;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              en    = 1'b0;
  logic [2:0]        op    = 3'd0;
  logic [LBL_W-1:0]  label = '0;
  logic              cond  = 1'b0;
  logic [ADDR_W-1:0] label_ext;
  logic [ADDR_W-1:0] pc;
  logic              taken, stack_full, stack_empty, err_ovf, err_unf;

  logic              en4    = 1'b0;
  logic [3:0]        label4 = 4'd0;
  logic [7:0]        label_ext4;
  logic [7:0]        pc4;
  logic              taken4, full4, empty4, ovf4, unf4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pc;
    bit taken;
    bit full;
    bit empty;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];

  int m_pc;
  bit m_taken, m_ovf, m_unf;
  int m_stk[$];

  jump_unit #(.ADDR_W(ADDR_W), .LBL_W(LBL_W), .STACK_DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset(reset), .en(en), .op(op), .label(label), .cond(cond),
    .label_ext(label_ext), .pc(pc), .taken(taken), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  jump_unit #(.ADDR_W(8), .LBL_W(4), .STACK_DEPTH(DEPTH)) u_dut4 (
    .clock(clock), .reset(reset), .en(en4), .op(op), .label(label4), .cond(cond),
    .label_ext(label_ext4), .pc(pc4), .taken(taken4), .stack_full(full4),
    .stack_empty(empty4), .err_ovf(ovf4), .err_unf(unf4)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sext(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.pc    = m_pc;
    e.taken = m_taken;
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // Reference behaviour: plain arithmetic on ints and a queue used as the stack
  task automatic model_step(input int o, input int l, input bit c);
    int nxt;
    nxt = (m_pc + 1) & MASK;
    case (o)
      1: begin m_pc = l & MASK; m_taken = 1; end
      2: begin m_pc = (m_pc + sext(l, LBL_W)) & MASK; m_taken = 1; end
      3: begin
        if (c) begin m_pc = (m_pc + sext(l, LBL_W)) & MASK; m_taken = 1; end
        else begin m_pc = nxt; m_taken = 0; end
      end
      4: begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(nxt); m_pc = l & MASK; m_taken = 1;
        end else begin
          m_pc = nxt; m_taken = 0; m_ovf = 1;
        end
      end
      5: begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back(); m_taken = 1;
        end else begin
          m_pc = nxt; m_taken = 0; m_unf = 1;
        end
      end
      default: begin m_pc = nxt; m_taken = 0; end
    endcase
  endtask

  task automatic drive_now(input bit e, input int o, input int l, input bit c);
    en    = e;
    op    = 3'(o);
    label = LBL_W'(l);
    cond  = c;
    if (e) model_step(o, l, c);
    exp_q.push_back(snap());
    #1;
    chk("label_ext_w8", 32'(label_ext), 32'(label));
  endtask

  task automatic do_op(input bit e, input int o, input int l, input bit c);
    @(negedge clock);
    drive_now(e, o, l, c);
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, "_pc"},    32'(pc),          32'(e.pc));
    chk({tag, "_taken"}, 32'(taken),       32'(e.taken));
    chk({tag, "_full"},  32'(stack_full),  32'(e.full));
    chk({tag, "_empty"}, 32'(stack_empty), 32'(e.empty));
    chk({tag, "_ovf"},   32'(err_ovf),     32'(e.ovf));
    chk({tag, "_unf"},   32'(err_unf),     32'(e.unf));
  endtask

  // Monitor: one prediction retires per rising edge that had stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_state("mon", e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t rs;
    int o, l;
    bit e, c;

    // Reset held across edges with a live JMP applied: nothing may move
    #1 reset = 1'b1;
    en = 1'b1; op = 3'd1; label = 8'h55;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    chk_state("in_reset", snap());

    // First op executes on the first edge after release
    @(negedge clock);
    reset = 1'b0;
    drive_now(1, 1, 8'h02, 0);

    // Sign extension with a 4-bit label
    label4 = 4'b1010; #1; chk("sext_neg", 32'(label_ext4), 32'h0000_00FA);
    label4 = 4'b0101; #1; chk("sext_pos", 32'(label_ext4), 32'h0000_0005);
    for (int i = 0; i < 16; i++) begin
      label4 = 4'(i); #1;
      chk("sext_sweep", 32'(label_ext4), 32'(sext(i, 4) & 8'hFF));
    end

    // Relative branch wrapping below zero, then NEXT wrapping past the top
    do_op(1, 2, 8'hFD, 0);
    do_op(1, 0, 8'h33, 1);

    // Conditional branch not taken / taken
    do_op(1, 1, 8'h10, 0);
    do_op(1, 3, 8'h04, 0);
    do_op(1, 1, 8'h10, 0);
    do_op(1, 3, 8'h04, 1);

    // Nested call/return
    do_op(1, 1, 8'h20, 0);
    do_op(1, 4, 8'h40, 0);
    do_op(1, 4, 8'h60, 0);
    do_op(1, 5, 8'hAA, 1);
    do_op(1, 5, 8'h55, 0);

    // Overflow then underflow, flags sticky, ops keep running
    for (int i = 0; i < 5; i++) do_op(1, 4, 8'h80 + i, 0);
    for (int i = 0; i < 5; i++) do_op(1, 5, 8'h00, 0);
    do_op(1, 2, 8'h05, 0);
    do_op(1, 7, 8'h11, 1);
    do_op(1, 6, 8'h22, 0);

    // Hold with en low
    for (int i = 0; i < 3; i++) do_op(0, 1, 8'hC3, 1);

    // Async reset pulse between edges with two entries stacked
    do_op(1, 4, 8'h30, 0);
    do_op(1, 4, 8'h50, 0);
    @(negedge clock);
    en = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    model_reset();
    rs = snap();
    chk_state("async_rst", rs);

    // Stack must be empty after reset: RET underflows
    do_op(1, 5, 8'h00, 0);

    // Randomized traffic biased toward CALL/RET
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      o = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(4, 5));
      l = int'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      do_op(e, o, l, c);
      if (i == 200) begin
        @(negedge clock);
        en = 1'b0;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        model_reset();
        rs = snap();
        chk_state("rand_rst", rs);
      end
    end

    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
